mips_lsu: RTL
=============

Name: mips_lsu

Overview:
- Load/store unit between the single-cycle datapath and the byte-addressed, big-endian data memory (1024 bytes; byte at A drives bits 31:24 of the word read at A).
- Accepts one load/store request at a time on a valid/ready handshake.
- Always drives the memory with word-aligned addresses.
- Performs read-modify-write for byte and halfword stores, sign- or zero-extends sub-word loads, and flags misaligned, illegal or out-of-range requests.

Parameters:
- MEM_BYTES, 1024, size of the data memory in bytes; any access whose last byte is at or beyond this address is an error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  LSU can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_op  input  3  MIPS funct3-style size code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified for byte/half.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result, extended per req_op; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid; request rejected, no memory access made.
- mem_address  output  32  to data memory; always {addr[31:2],2'b00}.
- mem_write_data  output  32  to data memory.
- sig_mem_read  output  1  memory read strobe.
- sig_mem_write  output  1  memory write strobe.
- mem_read_data  input  32  from data memory; combinational on mem_address.

Behaviour:
- Reset values: req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_address=0, mem_write_data=0; sig_mem_read=0, sig_mem_write=0; state IDLE.
- Reset is asynchronous. Asserting it mid-operation drops both strobes immediately; an interrupted store is not retried and gives no response.
- All outputs are registered.
- States: IDLE, READ, WRITE, RESP.
- IDLE: on req_valid & req_ready, latch we, op, addr, wdata and check legality.
  - Illegal op (011, 110, 111), or store with op 100/101 -> error.
  - Half with addr[0]=1, or word with addr[1:0]!=0 -> error.
  - addr + size - 1 >= MEM_BYTES -> error.
  - Error -> RESP with resp_err=1.
  - Legal load -> READ.
  - Legal word store -> WRITE.
  - Legal byte/half store -> READ.
- READ: sig_mem_read=1 for exactly one cycle; capture mem_read_data at the cycle's end.
  - Load: select the byte/half by addr[1:0] (big-endian lanes: offset 0 = bits 31:24, half offset 0 = bits 31:16), extend, go to RESP.
  - Sub-word store: merge req_wdata[7:0] or [15:8..7:0] into the same lanes, go to WRITE.
- WRITE: sig_mem_write=1 for exactly one cycle, with mem_address and mem_write_data stable the whole cycle; then RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. There is no response backpressure.
- Latency from the accept edge to resp_valid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- sig_mem_read and sig_mem_write are never high together. Both are low in IDLE and RESP.
- req_ready is low from the accept edge through the RESP cycle, so the next request can be accepted the cycle after RESP.
- Inputs may change after acceptance without effect.

Decomposition:
- Shared package mips_lsu_pkg:
  - op codes OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU
  - state encoding
  - a size function op -> bytes
- One natural sub-module, mips_lsu_align: combinational lane extract/extend for loads and lane merge for stores, keyed by op and addr[1:0]. It is reused for both directions.

Test Plan:
- Memory words at 0x10 = 0x8899AABB. lb 0x11 -> resp_rdata 0xFFFFFF99 after 2 cycles. lbu 0x11 -> 0x00000099. lh 0x12 -> 0xFFFFAABB. lhu 0x12 -> 0x0000AABB.
- sw 0x20 data 0x12345678, then lw 0x20 -> 0x12345678. Exactly one sig_mem_write cycle, mem_address=0x20.
- Memory 0x20 = 0x12345678. sb 0x22 data 0x000000EE -> READ then WRITE with mem_write_data 0x1234EE78; resp after 3 cycles. sh 0x20 data 0xCAFE -> word 0xCAFE EE78.
- lw 0x21, sh 0x23, op 011, and lw 0x3FE (MEM_BYTES=1024) -> resp_err=1 one cycle after accept, no strobe ever asserted.
- Drop rst_n during the WRITE cycle of sb -> sig_mem_write falls without a clock edge, memory unchanged apart from any combinational write, no resp_valid, req_ready=1 after release.
- Back-to-back requests with req_valid held high -> req_ready low for 2 or 3 cycles per request, exactly one resp_valid each, in order.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg: op codes, FSM encoding and access-size helper shared by the load/store unit
package mips_lsu_pkg;
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  function automatic logic [2:0] op_size(input logic [2:0] op);
    return op[1] ? 3'd4 : op[0] ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/mips_lsu_align.sv
// mips_lsu_align: big-endian lane extract/extend for loads and lane merge for sub-word stores
module mips_lsu_align
  import mips_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  assign sh = {~off, 3'b000};
  assign b = 8'(word >> sh);
  assign h = off[1] ? word[15:0] : word[31:16];
  assign rdata = op == OP_LB  ? {{24{b[7]}}, b} :
                 op == OP_LBU ? {24'b0, b} :
                 op == OP_LH  ? {{16{h[15]}}, h} :
                 op == OP_LHU ? {16'b0, h} : word;
  assign merged = op[0] ? (off[1] ? {word[31:16], wdata} : {wdata, word[15:0]}) :
                  (word & ~(32'h0000_00FF << sh)) | ({24'b0, wdata[7:0]} << sh);
endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: load/store unit with legality checks, sub-word read-modify-write and registered memory interface
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        sig_mem_read,
  output logic        sig_mem_write,
  input  logic [31:0] mem_read_data
);
  state_t      state, state_n;
  logic        we_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic [31:0] ld_data, st_data, rdata_n, addr_n, wd_n;
  logic        accept, bad_op, misal, oob, err, word_st, rd_n, wr_n, rerr_n;
  assign accept = req_valid && req_ready;
  assign bad_op = req_op == 3'b011 || req_op[2:1] == 2'b11 || (req_we && req_op[2]);
  assign misal = (req_op[1:0] == 2'b01 && req_addr[0]) || (req_op == OP_LW && req_addr[1:0] != 2'b00);
  assign oob = {1'b0, req_addr} + 33'(op_size(req_op)) > 33'(MEM_BYTES);
  assign err = bad_op || misal || oob;
  assign word_st = req_we && req_op == OP_LW;
  mips_lsu_align u_align (
    .op    (op_q),
    .off   (off_q),
    .word  (mem_read_data),
    .wdata (wdata_q),
    .rdata (ld_data),
    .merged(st_data)
  );
  always_comb begin
    state_n = state;
    rd_n = 1'b0;
    wr_n = 1'b0;
    rerr_n = 1'b0;
    rdata_n = '0;
    addr_n = mem_address;
    wd_n = mem_write_data;
    case (state)
      IDLE: if (accept) begin
        state_n = err ? RESP : word_st ? WRITE : READ;
        addr_n = {req_addr[31:2], 2'b00};
        wd_n = word_st ? req_wdata : mem_write_data;
        rd_n = !err && !word_st;
        wr_n = !err && word_st;
        rerr_n = err;
      end
      READ: begin
        state_n = we_q ? WRITE : RESP;
        wr_n = we_q;
        wd_n = we_q ? st_data : mem_write_data;
        rdata_n = we_q ? '0 : ld_data;
      end
      WRITE: state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
      mem_address <= '0;
      mem_write_data <= '0;
      sig_mem_read <= 1'b0;
      sig_mem_write <= 1'b0;
      we_q <= 1'b0;
      op_q <= OP_LB;
      off_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      req_ready <= state_n == IDLE;
      resp_valid <= state_n == RESP;
      resp_err <= rerr_n;
      resp_rdata <= rdata_n;
      mem_address <= addr_n;
      mem_write_data <= wd_n;
      sig_mem_read <= rd_n;
      sig_mem_write <= wr_n;
      if (accept) begin
        we_q <= req_we;
        op_q <= req_op;
        off_q <= req_addr[1:0];
        wdata_q <= req_wdata[15:0];
      end
    end
endmodule
